// File: rtl/pwm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_pkg
// Description : Shared types and constants for the single-channel PWM
//               controller (FSM state encoding, default counter width).
// Revision    : 1.0 - initial release
// ============================================================================
package pwm_pkg;

  // Default width of counter, period and duty values.
  localparam int CNT_W_DEF = 8;

  // Controller operating state.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

endpackage : pwm_pkg
`default_nettype wire

// File: rtl/pwm_shadow_cfg.sv
`default_nettype none
// ============================================================================
// Module      : pwm_shadow_cfg
// Description : Configuration front end of the PWM controller. Owns the
//               active period/duty registers, the shadow copies, the pending
//               flag and cfg_ready. Loads directly while idle; while running,
//               captures into the shadow and applies it on a wrap edge.
// Ports       : ck, rst          - clock, async active-high reset
//               in_idle          - controller currently in IDLE
//               wrap             - this edge ends a period (running, cnt==per)
//               cfg_valid/ready  - configuration handshake
//               cfg_period/duty  - requested configuration values
//               per_act/duty_act - registered active configuration
//               per_nxt/duty_nxt - value the active registers take this edge
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_shadow_cfg
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PER_DEF  = 255,
  parameter int DUTY_DEF = 0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             in_idle,
  input  logic             wrap,
  input  logic             cfg_valid,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             cfg_ready,
  output logic [CNT_W-1:0] per_act,
  output logic [CNT_W-1:0] duty_act,
  output logic [CNT_W-1:0] per_nxt,
  output logic [CNT_W-1:0] duty_nxt
);

  logic [CNT_W-1:0] sh_per;
  logic [CNT_W-1:0] sh_duty;
  logic             pend;
  logic             xfer;
  logic             apply;

  // A transfer only occurs while cfg_ready=1, which implies pend=0, so a
  // capture and an apply can never both happen on the same edge.
  assign xfer  = cfg_valid & cfg_ready;
  assign apply = wrap & pend;

  // Next active values are exported so the controller can compute the
  // registered compare outputs against the configuration that will govern
  // the cycle being entered (first RUN cycle, first cycle after a wrap).
  always_comb begin
    per_nxt  = per_act;
    duty_nxt = duty_act;
    if (in_idle && xfer) begin
      per_nxt  = cfg_period;
      duty_nxt = cfg_duty;
    end else if (apply) begin
      per_nxt  = sh_per;
      duty_nxt = sh_duty;
    end
  end

  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      per_act   <= CNT_W'(PER_DEF);
      duty_act  <= CNT_W'(DUTY_DEF);
      sh_per    <= CNT_W'(PER_DEF);
      sh_duty   <= CNT_W'(DUTY_DEF);
      pend      <= 1'b0;
      cfg_ready <= 1'b1;
    end else begin
      per_act  <= per_nxt;
      duty_act <= duty_nxt;
      if (!in_idle && xfer) begin
        sh_per    <= cfg_period;
        sh_duty   <= cfg_duty;
        pend      <= 1'b1;
        cfg_ready <= 1'b0;
      end else if (apply) begin
        pend      <= 1'b0;
        cfg_ready <= 1'b1;
      end
    end
  end

endmodule : pwm_shadow_cfg
`default_nettype wire

// File: rtl/pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pwm_ctrl
// Description : Single-channel PWM controller. Free-running period counter,
//               duty compare and an IDLE/RUN/DRAIN sequencer. Configuration
//               changes take effect only at period boundaries so pulses are
//               never truncated. All outputs are registered.
// Ports       : ck          - system clock (rising edge)
//               rst         - asynchronous active-high reset
//               en          - run request (level)
//               cfg_valid   - new configuration offered
//               cfg_ready   - configuration can be accepted
//               cfg_period  - requested terminal count
//               cfg_duty    - requested high time in cycles
//               pwm_out     - registered PWM output
//               cnt         - current counter value
//               period_end  - high while cnt == active period
//               busy        - high in RUN or DRAIN
// Revision    : 1.0 - initial release
// ============================================================================
module pwm_ctrl
  import pwm_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int PER_DEF  = 255,
  parameter int DUTY_DEF = 0
) (
  input  logic             ck,
  input  logic             rst,
  input  logic             en,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [CNT_W-1:0] cfg_period,
  input  logic [CNT_W-1:0] cfg_duty,
  output logic             pwm_out,
  output logic [CNT_W-1:0] cnt,
  output logic             period_end,
  output logic             busy
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt_nxt;
  logic [CNT_W-1:0] per_act;
  logic [CNT_W-1:0] duty_act;
  logic [CNT_W-1:0] per_nxt;
  logic [CNT_W-1:0] duty_nxt;
  logic             in_idle;
  logic             wrap;
  logic             busy_nxt;

  assign in_idle = (state == IDLE);
  assign wrap    = !in_idle && (cnt == per_act);

  pwm_shadow_cfg #(
    .CNT_W    (CNT_W),
    .PER_DEF  (PER_DEF),
    .DUTY_DEF (DUTY_DEF)
  ) u_shadow (
    .ck         (ck),
    .rst        (rst),
    .in_idle    (in_idle),
    .wrap       (wrap),
    .cfg_valid  (cfg_valid),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .cfg_ready  (cfg_ready),
    .per_act    (per_act),
    .duty_act   (duty_act),
    .per_nxt    (per_nxt),
    .duty_nxt   (duty_nxt)
  );

  // Next state and next counter value.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (en) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        if (!en) begin
          state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        cnt_nxt = wrap ? '0 : cnt + CNT_W'(1);
        // en wins over the wrap so a re-request at the last count
        // continues straight into the next period without a gap.
        if (en) begin
          state_nxt = RUN;
        end else if (wrap) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  assign busy_nxt = (state_nxt != IDLE);

  // Outputs are computed from the values that will be current after this
  // edge, so pwm_out/period_end always agree with cnt and the active
  // configuration in the same cycle.
  always_ff @(posedge ck or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      pwm_out    <= 1'b0;
      period_end <= 1'b0;
      busy       <= 1'b0;
    end else begin
      state      <= state_nxt;
      cnt        <= cnt_nxt;
      busy       <= busy_nxt;
      pwm_out    <= busy_nxt && (cnt_nxt < duty_nxt);
      period_end <= busy_nxt && (cnt_nxt == per_nxt);
    end
  end

endmodule : pwm_ctrl
`default_nettype wire

// File: tb/tb_pwm_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwm_ctrl
// Description : Self-checking bench for pwm_ctrl. A behavioural model
//               predicts the outputs of every clock edge; predictions are
//               queued when stimulus is applied and compared after the edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pwm_ctrl;

  localparam int W = 8;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         en = 1'b0;
  logic         cfg_valid = 1'b0;
  logic [W-1:0] cfg_period = '0;
  logic [W-1:0] cfg_duty = '0;
  logic         cfg_ready;
  logic         pwm_out;
  logic [W-1:0] cnt;
  logic         period_end;
  logic         busy;

  pwm_ctrl #(.CNT_W(W), .PER_DEF(255), .DUTY_DEF(0)) dut (
    .ck         (ck),
    .rst        (rst),
    .en         (en),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_period (cfg_period),
    .cfg_duty   (cfg_duty),
    .pwm_out    (pwm_out),
    .cnt        (cnt),
    .period_end (period_end),
    .busy       (busy)
  );

  always #5 ck = ~ck;

  typedef struct packed {
    logic         pwm;
    logic [W-1:0] cnt;
    logic         pe;
    logic         busy;
    logic         rdy;
  } exp_t;

  exp_t sb[$];

  int checks = 0;
  int errors = 0;
  int hi_cnt = 0;
  int pe_cnt = 0;

  // Model state: 0 idle, 1 run, 2 drain.
  int           m_state;
  logic [W-1:0] m_cnt, m_per, m_duty, m_sp, m_sd;
  logic         m_pend;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    m_state = 0;
    m_cnt   = '0;
    m_per   = 8'd255;
    m_duty  = 8'd0;
    m_sp    = 8'd255;
    m_sd    = 8'd0;
    m_pend  = 1'b0;
    sb.delete();
  endtask

  // Advance the model by one edge using the inputs currently driven.
  task automatic model_step();
    bit   running, wrapping, xfer, p0;
    exp_t e;
    running  = (m_state != 0);
    wrapping = running && (m_cnt == m_per);
    xfer     = cfg_valid && !m_pend;
    p0       = m_pend;
    if (!running && xfer) begin
      m_per  = cfg_period;
      m_duty = cfg_duty;
    end else if (xfer) begin
      m_sp   = cfg_period;
      m_sd   = cfg_duty;
      m_pend = 1'b1;
    end
    if (wrapping && p0) begin
      m_per  = m_sp;
      m_duty = m_sd;
      m_pend = 1'b0;
    end
    if (!running) begin
      if (en) begin
        m_state = 1;
        m_cnt   = '0;
      end
    end else begin
      m_cnt = wrapping ? 8'd0 : m_cnt + 8'd1;
      if (en)               m_state = 1;
      else if (m_state == 1) m_state = 2;
      else if (wrapping)    m_state = 0;
    end
    e.busy = (m_state != 0);
    e.cnt  = m_cnt;
    e.pwm  = e.busy && (m_cnt < m_duty);
    e.pe   = e.busy && (m_cnt == m_per);
    e.rdy  = !m_pend;
    sb.push_back(e);
  endtask

  // One clock: predict, clock, compare one cycle later.
  task automatic cyc();
    exp_t e;
    model_step();
    @(posedge ck);
    #1;
    e = sb.pop_front();
    check("pwm_out",    32'(pwm_out),    32'(e.pwm));
    check("cnt",        32'(cnt),        32'(e.cnt));
    check("period_end", 32'(period_end), 32'(e.pe));
    check("busy",       32'(busy),       32'(e.busy));
    check("cfg_ready",  32'(cfg_ready),  32'(e.rdy));
    hi_cnt += int'(pwm_out);
    pe_cnt += int'(period_end);
  endtask

  task automatic wait_cnt(input logic [W-1:0] v);
    bit found;
    found = 1'b0;
    for (int i = 0; i < 300 && !found; i++) begin
      if (cnt == v) found = 1'b1;
      else cyc();
    end
    if (!found) check("wait_cnt_timeout", 32'(cnt), 32'(v));
  endtask

  task automatic cfg_write(input logic [W-1:0] p, input logic [W-1:0] d);
    bit done;
    done       = 1'b0;
    cfg_period = p;
    cfg_duty   = d;
    cfg_valid  = 1'b1;
    for (int i = 0; i < 300 && !done; i++) begin
      done = cfg_ready;
      cyc();
    end
    cfg_valid = 1'b0;
    if (!done) check("cfg_write_timeout", 32'(cfg_ready), 32'd1);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_cnt"},   32'(cnt),        32'd0);
    check({tag, "_pwm"},   32'(pwm_out),    32'd0);
    check({tag, "_pe"},    32'(period_end), 32'd0);
    check({tag, "_busy"},  32'(busy),       32'd0);
    check({tag, "_ready"}, 32'(cfg_ready),  32'd1);
  endtask

  initial begin
    int n;
    int bz;
    model_reset();

    // Reset state
    repeat (2) @(posedge ck);
    #1;
    check_reset_vals("reset");
    rst = 1'b0;

    // 1: load 9/3 in IDLE, run
    cfg_write(8'd9, 8'd3);
    en = 1'b1;
    hi_cnt = 0; pe_cnt = 0;
    repeat (20) cyc();
    check("t1_high_cycles", 32'(hi_cnt), 32'd6);
    check("t1_period_ends", 32'(pe_cnt), 32'd2);
    check("t1_busy", 32'(busy), 32'd1);

    // 2: reconfigure to 4/2 mid-period
    wait_cnt(8'd5);
    cfg_write(8'd4, 8'd2);
    check("t2_ready_low", 32'(cfg_ready), 32'd0);
    wait_cnt(8'd0);
    check("t2_ready_back", 32'(cfg_ready), 32'd1);
    hi_cnt = 0; pe_cnt = 0;
    repeat (10) cyc();
    check("t2_high_cycles", 32'(hi_cnt), 32'd4);
    check("t2_period_ends", 32'(pe_cnt), 32'd2);

    // 3: duty 0 then duty above period
    cfg_write(8'd9, 8'd0);
    repeat (12) cyc();
    hi_cnt = 0; pe_cnt = 0;
    repeat (20) cyc();
    check("t3_duty0_high", 32'(hi_cnt), 32'd0);
    check("t3_duty0_pe",   32'(pe_cnt), 32'd2);
    cfg_write(8'd9, 8'd12);
    repeat (12) cyc();
    hi_cnt = 0; pe_cnt = 0;
    repeat (20) cyc();
    check("t3_full_high", 32'(hi_cnt), 32'd20);
    check("t3_full_pe",   32'(pe_cnt), 32'd2);

    // 4: drain to idle, then drain with re-enable
    cfg_write(8'd9, 8'd3);
    repeat (12) cyc();
    wait_cnt(8'd4);
    en = 1'b0;
    n = 0;
    for (int i = 0; i < 30 && busy; i++) begin
      cyc();
      n++;
    end
    check("t4_drain_cycles", 32'(n), 32'd6);
    check("t4_idle_cnt", 32'(cnt), 32'd0);
    check("t4_idle_pwm", 32'(pwm_out), 32'd0);
    en = 1'b1;
    cyc();
    wait_cnt(8'd4);
    en = 1'b0;
    wait_cnt(8'd7);
    en = 1'b1;
    bz = 0;
    for (int i = 0; i < 15; i++) begin
      cyc();
      bz += int'(busy);
    end
    check("t4_busy_held", 32'(bz), 32'd15);

    // 5: async reset between edges
    wait_cnt(8'd6);
    #2;
    rst = 1'b1;
    #1;
    check_reset_vals("t5_async");
    model_reset();
    @(posedge ck);
    #1;
    rst = 1'b0;
    check_reset_vals("t5_after");
    hi_cnt = 0; pe_cnt = 0;
    repeat (256) cyc();
    check("t5_def_period_ends", 32'(pe_cnt), 32'd1);
    check("t5_def_duty_high", 32'(hi_cnt), 32'd0);
    en = 1'b0;
    for (int i = 0; i < 300 && busy; i++) cyc();
    check("t5_back_idle", 32'(busy), 32'd0);

    // 6: period 0
    cfg_write(8'd0, 8'd1);
    en = 1'b1;
    hi_cnt = 0; pe_cnt = 0;
    repeat (5) cyc();
    check("t6_high", 32'(hi_cnt), 32'd5);
    check("t6_pe",   32'(pe_cnt), 32'd5);
    check("t6_cnt",  32'(cnt),    32'd0);
    cfg_write(8'd0, 8'd0);
    cyc();
    check("t6_applied_pwm", 32'(pwm_out), 32'd0);
    repeat (3) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule : tb_pwm_ctrl
`default_nettype wire
